// File: rtl/video_sig_recover.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_sig_recover : regenerates active-region coordinates, new-frame pulse
//                     and frame count from a raw hs/vs/ad stream; reports lock
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module video_sig_recover #(
   parameter int ACTIVE_H_PIXELS = 1280,
   parameter int ACTIVE_LINES    = 720,
   parameter int FPS             = 60,
   parameter int LOCK_FRAMES     = 2,
   localparam int HW = $clog2(ACTIVE_H_PIXELS + 1),
   localparam int VW = $clog2(ACTIVE_LINES + 1)
) (
   input  logic          pixel_clk_in,
   input  logic          rst_in,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          ad_in,
   output logic [HW-1:0] hcount_out,
   output logic [VW-1:0] vcount_out,
   output logic          de_out,
   output logic          nf_out,
   output logic [5:0]    fc_out,
   output logic          locked_out,
   output logic          err_out
);

   localparam int GW = $clog2(LOCK_FRAMES + 1);
   localparam logic [HW-1:0] C_H_MAX  = HW'(ACTIVE_H_PIXELS);
   localparam logic [HW-1:0] C_H_LAST = HW'(ACTIVE_H_PIXELS - 1);
   localparam logic [VW-1:0] C_V_MAX  = VW'(ACTIVE_LINES);
   localparam logic [5:0]    C_FC_MAX = 6'(FPS - 1);
   localparam logic [GW-1:0] C_LOCK_N = GW'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_SYNCING  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          hs_p_q, hs_p_d, vs_p_q, vs_p_d, ad_p_q, ad_p_d;
   logic [HW-1:0] hcount_q, hcount_d;
   logic [VW-1:0] vcount_q, vcount_d;
   logic          de_q, de_d, nf_q, nf_d, locked_q, locked_d, err_q, err_d;
   logic          bad_q, bad_d;
   logic [5:0]    fc_q, fc_d;
   logic [GW-1:0] good_q, good_d;

   logic w_vs_rise, w_hs_rise, w_ad_rise, w_ad_fall, w_frame_good;
   logic [5:0] w_fc_inc;

   assign w_vs_rise = vs_in & ~vs_p_q;
   assign w_hs_rise = hs_in & ~hs_p_q;
   assign w_ad_rise = ad_in & ~ad_p_q;
   assign w_ad_fall = ~ad_in & ad_p_q;
   assign w_fc_inc  = (fc_q == C_FC_MAX) ? 6'd0 : fc_q + 6'd1;

   always_comb begin
      state_d  = state_q;
      hs_p_d   = hs_in;
      vs_p_d   = vs_in;
      ad_p_d   = ad_in;
      hcount_d = hcount_q;
      vcount_d = vcount_q;
      de_d     = ad_in;
      nf_d     = 1'b0;
      err_d    = 1'b0;
      locked_d = locked_q;
      bad_d    = bad_q;
      fc_d     = fc_q;
      good_d   = good_q;

      // Line-level bookkeeping for the frame in progress
      if (ad_in && ad_p_q && (hcount_q != C_H_MAX)) begin
         hcount_d = hcount_q + 1'b1;
         if (hcount_d == C_H_MAX) bad_d = 1'b1;
      end
      if (w_ad_fall) begin
         if (hcount_q != C_H_LAST) bad_d = 1'b1;
         if (vcount_q != C_V_MAX) vcount_d = vcount_q + 1'b1;
      end
      if (w_hs_rise && ad_in) bad_d = 1'b1;

      w_frame_good = ~bad_d && (vcount_d == C_V_MAX);

      // Frame boundary is resolved before any coincident ad rise
      if (w_vs_rise) begin
         nf_d     = 1'b1;
         vcount_d = '0;
         bad_d    = 1'b0;
         case (state_q)
            ST_UNLOCKED: begin
               state_d = ST_SYNCING;
               good_d  = '0;
            end
            ST_SYNCING: begin
               if (w_frame_good) begin
                  good_d = good_q + 1'b1;
                  if (good_d == C_LOCK_N) begin
                     state_d  = ST_LOCKED;
                     locked_d = 1'b1;
                     fc_d     = w_fc_inc;
                  end
               end else begin
                  err_d  = 1'b1;
                  good_d = '0;
               end
            end
            ST_LOCKED: begin
               fc_d = w_fc_inc;
               if (!w_frame_good) begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
                  state_d  = ST_UNLOCKED;
               end
            end
            default: state_d = ST_UNLOCKED;
         endcase
      end

      if (w_ad_rise) begin
         hcount_d = '0;
         if (vcount_d == C_V_MAX) bad_d = 1'b1;
      end
   end

   always_ff @(posedge pixel_clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q  <= ST_UNLOCKED;
         hs_p_q   <= 1'b0;
         vs_p_q   <= 1'b0;
         ad_p_q   <= 1'b0;
         hcount_q <= '0;
         vcount_q <= '0;
         de_q     <= 1'b0;
         nf_q     <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
         bad_q    <= 1'b0;
         fc_q     <= '0;
         good_q   <= '0;
      end else begin
         state_q  <= state_d;
         hs_p_q   <= hs_p_d;
         vs_p_q   <= vs_p_d;
         ad_p_q   <= ad_p_d;
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         de_q     <= de_d;
         nf_q     <= nf_d;
         err_q    <= err_d;
         locked_q <= locked_d;
         bad_q    <= bad_d;
         fc_q     <= fc_d;
         good_q   <= good_d;
      end
   end

   assign hcount_out = hcount_q;
   assign vcount_out = vcount_q;
   assign de_out     = de_q;
   assign nf_out     = nf_q;
   assign fc_out     = fc_q;
   assign locked_out = locked_q;
   assign err_out    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_sig_recover.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_video_sig_recover : directed bench on a shrunken 8x4 geometry
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_video_sig_recover;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int HT = 12;
   localparam int FPS = 60;

   logic       clk = 1'b0;
   logic       rst, hs, vs, ad;
   logic [3:0] hcount;
   logic [2:0] vcount;
   logic       de, nf, locked, err;
   logic [5:0] fc;

   video_sig_recover #(
      .ACTIVE_H_PIXELS(H),
      .ACTIVE_LINES   (V),
      .FPS            (FPS),
      .LOCK_FRAMES    (2)
   ) dut (
      .pixel_clk_in(clk),
      .rst_in      (rst),
      .hs_in       (hs),
      .vs_in       (vs),
      .ad_in       (ad),
      .hcount_out  (hcount),
      .vcount_out  (vcount),
      .de_out      (de),
      .nf_out      (nf),
      .fc_out      (fc),
      .locked_out  (locked),
      .err_out     (err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int nf_cnt, err_cnt, nf_wide, de_err, hmax, fc_skip, fc_wraps;
   int rise_idx, lock_rise_at, first_h, first_v, last_h, last_v;
   int nf_h, nf_v, nf_de;
   bit prev_nf, prev_locked, prev_vs, want_first;
   logic [5:0] prev_fc;

   task automatic check_val(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int all_outs();
      return int'({hcount, vcount, de, nf, fc, locked, err});
   endfunction

   task automatic clear_mon();
      nf_cnt = 0; err_cnt = 0; nf_wide = 0; de_err = 0; hmax = 0;
      fc_skip = 0; fc_wraps = 0; rise_idx = 0; lock_rise_at = -1;
      prev_nf = 0; prev_locked = 0; prev_vs = 0; prev_fc = '0; want_first = 0;
   endtask

   // One input sample, then observe the registered response 1 ns after the edge
   task automatic step(input logic h, input logic v, input logic a);
      hs = h; vs = v; ad = a;
      @(posedge clk);
      #1;
      if (de !== a) de_err++;
      if (nf) begin
         nf_cnt++;
         if (prev_nf) nf_wide++;
         nf_h = hcount; nf_v = vcount; nf_de = de;
         want_first = 1;
      end
      if (v && !prev_vs) begin
         rise_idx++;
         if (locked && !prev_locked && lock_rise_at < 0) lock_rise_at = rise_idx;
      end
      if (err) err_cnt++;
      if (de) begin
         if (want_first) begin
            first_h = hcount; first_v = vcount; want_first = 0;
         end
         last_h = hcount; last_v = vcount;
         if (int'(hcount) > hmax) hmax = hcount;
      end
      if (fc != prev_fc) begin
         if (int'(fc) != (int'(prev_fc) + 1) % FPS) fc_skip++;
         if (fc == 6'd0) fc_wraps++;
      end
      prev_nf = nf; prev_locked = locked; prev_vs = v; prev_fc = fc;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      rst = 1'b0;
      clear_mon();
   endtask

   task automatic do_line(input int len, input logic v);
      for (int i = 0; i < len; i++) step(0, v, 1);
      step(0, v, 0);
      step(1, v, 0);
      step(0, v, 0);
      step(0, v, 0);
   endtask

   task automatic do_frame(input int nlines, input int sidx, input int slen, input logic vblank);
      for (int l = 0; l < nlines; l++) do_line((l == sidx) ? slen : H, 1'b0);
      for (int i = 0; i < HT; i++) step(0, vblank, 0);
      for (int i = 0; i < HT; i++) step(0, 0, 0);
   endtask

   int e0;

   initial begin
      rst = 1'b1; hs = 0; vs = 0; ad = 0;
      clear_mon();
      step(0, 0, 0);
      check_val("reset_outputs", all_outs(), 0);
      do_reset();

      // Clean stream: lock on the third vs rise
      do_frame(V, -1, 0, 1);
      do_frame(V, -1, 0, 1);
      check_val("first_pix_h", first_h, 0);
      check_val("first_pix_v", first_v, 0);
      check_val("last_pix_h", last_h, H - 1);
      check_val("last_pix_v", last_v, V - 1);
      do_frame(V, -1, 0, 1);
      do_frame(V, -1, 0, 1);
      check_val("lock_rise_idx", lock_rise_at, 3);
      check_val("locked_clean", locked, 1);
      check_val("err_clean", err_cnt, 0);
      check_val("nf_count", nf_cnt, 4);
      check_val("nf_width", nf_wide, 0);
      check_val("fc_after_lock", fc, 2);

      // Short line while locked
      e0 = err_cnt;
      do_frame(V, 1, H - 1, 1);
      check_val("short_err", err_cnt - e0, 1);
      check_val("short_unlock", locked, 0);
      do_frame(V, -1, 0, 1);
      do_frame(V, -1, 0, 1);
      check_val("relock_early", locked, 0);
      do_frame(V, -1, 0, 1);
      check_val("relock", locked, 1);
      check_val("relock_err", err_cnt - e0, 1);

      // Over-long line saturates
      e0 = err_cnt; hmax = 0;
      do_frame(V, 2, H + 3, 1);
      check_val("sat_hmax", hmax, H);
      check_val("sat_err", err_cnt - e0, 1);
      check_val("sat_unlock", locked, 0);
      check_val("de_track", de_err, 0);

      // Asynchronous reset mid-line
      for (int i = 0; i < 5; i++) step(0, 0, 1);
      rst = 1'b1;
      #1;
      check_val("async_reset", all_outs(), 0);
      step(0, 0, 0);
      step(0, 0, 0);
      rst = 1'b0;
      clear_mon();
      do_frame(V - 1, -1, 0, 1);
      check_val("first_vs_no_err", err_cnt, 0);
      for (int f = 0; f < 129; f++) do_frame(V, -1, 0, 1);
      check_val("fc_final", fc, 8);
      check_val("fc_skip", fc_skip, 0);
      check_val("fc_wraps", fc_wraps, 2);
      check_val("long_run_err", err_cnt, 0);

      // vs rise coincident with the first ad rise of a frame
      do_frame(V, -1, 0, 0);
      nf_de = 0; nf_h = -1; nf_v = -1;
      do_line(H, 1'b1);
      check_val("coinc_de", nf_de, 1);
      check_val("coinc_h", nf_h, 0);
      check_val("coinc_v", nf_v, 0);
      for (int l = 1; l < V; l++) do_line(H, 1'b0);
      for (int i = 0; i < HT; i++) step(0, 1, 0);
      for (int i = 0; i < HT; i++) step(0, 0, 0);
      check_val("coinc_err", err_cnt, 0);
      check_val("coinc_locked", locked, 1);

      // Missing line while syncing
      do_reset();
      do_frame(V, -1, 0, 1);
      do_frame(V, -1, 0, 1);
      do_frame(V - 1, -1, 0, 1);
      check_val("miss_err", err_cnt, 1);
      check_val("miss_locked", locked, 0);
      do_frame(V, -1, 0, 1);
      check_val("miss_cnt_reset", locked, 0);
      do_frame(V, -1, 0, 1);
      check_val("miss_relock", locked, 1);
      check_val("miss_err_total", err_cnt, 1);
      check_val("de_track_end", de_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
